// File: rtl/toom8_pkg.sv
// Shared constants, FSM encoding and lane helpers for the Toom-8 pointwise-multiply stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package toom8_pkg;

  localparam int PW    = 155;  // widest evaluated point (a13/b13)
  localparam int NPTS  = 15;   // points 0..13 plus infinity
  localparam int TAG_W = 4;    // enough to name every lane

  localparam logic [TAG_W-1:0] IDX_INF  = 4'd14;
  localparam logic [TAG_W-1:0] NPTS_CNT = 4'd15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Pick operand lane k out of a packed NPTS*PW bus; out-of-range k yields zero.
  function automatic logic [PW-1:0] lane_sel(input logic [NPTS*PW-1:0] v,
                                             input logic [TAG_W-1:0]   k);
    lane_sel = '0;
    for (int i = 0; i < NPTS; i++) begin
      if (k == i[TAG_W-1:0]) lane_sel = v[i*PW +: PW];
    end
  endfunction

endpackage

// File: rtl/toom8_signed_mul_pipe.sv
// Exact signed PW x PW -> 2*PW multiplier with a valid/tag sideband.
// Latency: LAT cycles from in_vld_i to out_vld_o.
// Backpressure: none; accepts one operand pair every cycle.
module toom8_signed_mul_pipe #(
  parameter int PW    = 155,
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  input  logic [PW-1:0]     a_i,
  input  logic [PW-1:0]     b_i,
  output logic              out_vld_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [2*PW-1:0]   out_dat_o
);

  // Operands are sign-extended to full product width so -2^(PW-1) squared stays exact.
  logic signed [2*PW-1:0] prod;
  assign prod = $signed({{PW{a_i[PW-1]}}, a_i}) * $signed({{PW{b_i[PW-1]}}, b_i});

  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [2*PW-1:0]  dat_q [LAT];

  // Shift register carrying the product and its sideband; reset flushes in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld_i;
      tag_q[0] <= in_tag_i;
      dat_q[0] <= prod;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld_o = vld_q[LAT-1];
  assign out_tag_o = tag_q[LAT-1];
  assign out_dat_o = dat_q[LAT-1];

endmodule

// File: rtl/toom8_pointwise_mult.sv
// Pointwise w_k = a_k * b_k over 15 Toom-8 points through one shared pipelined multiplier.
// Latency: out_valid rises 16+MUL_LAT cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module toom8_pointwise_mult
  import toom8_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NPTS*PW-1:0]     a_pts,
  input  logic [NPTS*PW-1:0]     b_pts,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NPTS*2*PW-1:0]   w_pts,
  output logic                   busy
);

  logic [1:0]            state_q, state_d;
  logic [TAG_W-1:0]      idx_q, idx_d;
  logic [TAG_W-1:0]      cnt_q, cnt_d;
  logic [NPTS*PW-1:0]    a_q, a_d, b_q, b_d;
  logic [NPTS*2*PW-1:0]  w_q, w_d;

  logic                  iss_vld;
  logic                  ret_vld;
  logic [TAG_W-1:0]      ret_tag;
  logic [2*PW-1:0]       ret_dat;
  logic                  retire;

  assign iss_vld = (state_q == ST_ISSUE);

  toom8_signed_mul_pipe #(
    .PW    (PW),
    .LAT   (MUL_LAT),
    .TAG_W (TAG_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (iss_vld),
    .in_tag_i  (idx_q),
    .a_i       (lane_sel(a_q, idx_q)),
    .b_i       (lane_sel(b_q, idx_q)),
    .out_vld_o (ret_vld),
    .out_tag_o (ret_tag),
    .out_dat_o (ret_dat)
  );

  // With short pipes retires already arrive while issue is still running.
  assign retire = ret_vld && (state_q == ST_ISSUE || state_q == ST_DRAIN);

  // Next-state: FSM sequencing, issue/retire counters and result lane writes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    if (retire) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < NPTS; k++) begin
        if (ret_tag == k[TAG_W-1:0]) w_d[k*2*PW +: 2*PW] = ret_dat;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_pts;
          b_d     = b_pts;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_INF) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == NPTS_CNT) state_d = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any job and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign w_pts     = w_q;

endmodule

// File: tb/tb_toom8_pointwise_mult.sv
module tb_toom8_pointwise_mult;
  import toom8_pkg::*;

  localparam int NI = 3;   // instances with MUL_LAT 3, 1, 8

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [NPTS*PW-1:0]   a_pts, b_pts;
  logic                 in_ready  [NI];
  logic                 out_valid [NI];
  logic                 busy      [NI];
  logic [NPTS*2*PW-1:0] w_pts     [NI];

  int checks = 0;
  int errors = 0;
  int lats [NI] = '{3, 1, 8};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 8;
    toom8_pointwise_mult #(.MUL_LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .a_pts     (a_pts),
      .b_pts     (b_pts),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .w_pts     (w_pts[g]),
      .busy      (busy[g])
    );
  end

  // Reference: each lane is an exact signed product, computed at full width.
  function automatic logic [NPTS*2*PW-1:0] ref_mul(input logic [NPTS*PW-1:0] a,
                                                   input logic [NPTS*PW-1:0] b);
    logic signed [PW-1:0]   ak, bk;
    logic signed [2*PW-1:0] x, y;
    ref_mul = '0;
    for (int k = 0; k < NPTS; k++) begin
      ak = a[k*PW +: PW];
      bk = b[k*PW +: PW];
      x = ak;
      y = bk;
      ref_mul[k*2*PW +: 2*PW] = x * y;
    end
  endfunction

  function automatic logic [NPTS*PW-1:0] rand_vec();
    logic [NPTS*PW-1:0] v;
    v = '0;
    for (int i = 0; i < (NPTS*PW)/32 + 1; i++) v = (v << 32) | (NPTS*PW)'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [NPTS*PW-1:0] a, input logic [NPTS*PW-1:0] b);
    a_pts = a;
    b_pts = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int g, input int maxc, output int n);
    n = 0;
    while (!out_valid[g] && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic vec1(output logic [NPTS*PW-1:0] a, output logic [NPTS*PW-1:0] b);
    logic [PW-1:0] t;
    for (int k = 0; k < NPTS; k++) begin
      a[k*PW +: PW] = PW'(k + 1);
      t = PW'(k + 2);
      b[k*PW +: PW] = -t;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int g = 0; g < NI; g++) begin
      checks++; if (out_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", g, out_valid[g]); end
      checks++; if (busy[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", g, busy[g]); end
      checks++; if (in_ready[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", g, in_ready[g]); end
      checks++; if (w_pts[g] !== '0) begin errors++; $display("FAIL reset_w_pts[%0d] nonzero", g); end
    end
  endtask

  task automatic test_basic();
    logic [NPTS*PW-1:0] a, b;
    logic [2*PW-1:0] e0, e14;
    int n;
    vec1(a, b);
    e0 = '0; e0 = e0 - 2;
    e14 = '0; e14 = e14 - 240;
    out_ready = 1'b1;
    do_accept(a, b);
    wait_out(0, 60, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL basic_latency got %0d want 19", n); end
    checks++; if (w_pts[0] !== ref_mul(a, b)) begin errors++; $display("FAIL basic_w_pts lanes differ from model"); end
    checks++; if (w_pts[0][0 +: 2*PW] !== e0) begin errors++; $display("FAIL basic_w0 got %0h want %0h", w_pts[0][0 +: 2*PW], e0); end
    checks++; if (w_pts[0][14*2*PW +: 2*PW] !== e14) begin errors++; $display("FAIL basic_w14 got %0h want %0h", w_pts[0][14*2*PW +: 2*PW], e14); end
    tick();
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin errors++; $display("FAIL basic_handshake out_valid %b in_ready %b want 0 1", out_valid[0], in_ready[0]); end
  endtask

  task automatic test_extreme();
    logic [NPTS*PW-1:0] a, b;
    logic [2*PW-1:0] e1, e2;
    int n;
    e1 = '0; e1[308] = 1'b1;
    e2 = '0; e2[154] = 1'b1; e2 = e2 - ((2*PW)'(1) << 308);
    for (int k = 0; k < NPTS; k++) begin
      a[k*PW +: PW] = '0; a[k*PW + PW - 1] = 1'b1;
      b[k*PW +: PW] = a[k*PW +: PW];
    end
    out_ready = 1'b1;
    do_accept(a, b);
    wait_out(0, 60, n);
    for (int k = 0; k < NPTS; k++) begin
      checks++; if (w_pts[0][k*2*PW +: 2*PW] !== e1) begin errors++; $display("FAIL extreme_sq lane %0d got %0h want %0h", k, w_pts[0][k*2*PW +: 2*PW], e1); end
    end
    tick();
    for (int k = 0; k < NPTS; k++) b[k*PW +: PW] = {1'b0, {(PW-1){1'b1}}};
    do_accept(a, b);
    wait_out(0, 60, n);
    for (int k = 0; k < NPTS; k++) begin
      checks++; if (w_pts[0][k*2*PW +: 2*PW] !== e2) begin errors++; $display("FAIL extreme_mix lane %0d got %0h want %0h", k, w_pts[0][k*2*PW +: 2*PW], e2); end
    end
    tick();
  endtask

  task automatic test_hold();
    logic [NPTS*PW-1:0] a, b;
    logic [NPTS*2*PW-1:0] exp_w;
    int n;
    int bad;
    a = rand_vec(); b = rand_vec();
    exp_w = ref_mul(a, b);
    out_ready = 1'b0;
    do_accept(a, b);
    wait_out(0, 60, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL hold_latency got %0d want 19", n); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      a_pts = rand_vec(); b_pts = rand_vec();
      tick();
      if (w_pts[0] !== exp_w || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin errors++; $display("FAIL hold_release out_valid %b in_ready %b want 0 1", out_valid[0], in_ready[0]); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_no_capture got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_abort();
    logic [NPTS*PW-1:0] a, b;
    int n;
    int seen;
    out_ready = 1'b1;
    do_accept(rand_vec(), rand_vec());
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || w_pts[0] !== '0) begin errors++; $display("FAIL abort_state out_valid %b in_ready %b w_zero %b want 0 1 1", out_valid[0], in_ready[0], w_pts[0] == '0); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid[0] !== 1'b0 || w_pts[0] !== '0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d cycles with output want 0", seen); end
    vec1(a, b);
    do_accept(a, b);
    wait_out(0, 60, n);
    checks++; if (n !== 19 || w_pts[0] !== ref_mul(a, b)) begin errors++; $display("FAIL abort_next_job latency %0d want 19 or lanes wrong", n); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NPTS*PW-1:0] ja [3];
    logic [NPTS*PW-1:0] jb [3];
    logic [NPTS*2*PW-1:0] exp_q [$];
    logic [NPTS*2*PW-1:0] e;
    int j, pulses, last;
    logic acc;
    for (int i = 0; i < 3; i++) begin ja[i] = rand_vec(); jb[i] = rand_vec(); end
    j = 0; pulses = 0; last = -1;
    out_ready = 1'b1;
    a_pts = ja[0]; b_pts = jb[0]; in_valid = 1'b1;
    for (int c = 1; c <= 150 && pulses < 3; c++) begin
      acc = in_valid && in_ready[0];
      tick();
      if (acc) begin
        exp_q.push_back(ref_mul(ja[j], jb[j]));
        j++;
        if (j < 3) begin a_pts = ja[j]; b_pts = jb[j]; end
        else in_valid = 1'b0;
      end
      if (out_valid[0]) begin
        pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (w_pts[0] !== e) begin errors++; $display("FAIL b2b_result job %0d lanes differ from model", pulses); end
        if (last >= 0) begin
          checks++; if (c - last !== 21) begin errors++; $display("FAIL b2b_period got %0d want 21", c - last); end
        end
        last = c;
      end
    end
    in_valid = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    tick();
  endtask

  task automatic test_lat_sweep();
    logic [NPTS*PW-1:0] a, b;
    logic [NPTS*2*PW-1:0] e;
    int lat [NI];
    apply_reset();
    out_ready = 1'b1;
    for (int job = 0; job < 2; job++) begin
      a = rand_vec(); b = rand_vec();
      e = ref_mul(a, b);
      for (int g = 0; g < NI; g++) lat[g] = 0;
      do_accept(a, b);
      for (int c = 1; c <= 40; c++) begin
        for (int g = 0; g < NI; g++) begin
          if (out_valid[g] && lat[g] == 0) begin
            lat[g] = c - 1;
            checks++; if (w_pts[g] !== e) begin errors++; $display("FAIL sweep_result lat%0d job %0d lanes differ from model", lats[g], job); end
          end
        end
        tick();
      end
      for (int g = 0; g < NI; g++) begin
        checks++; if (lat[g] !== 16 + lats[g]) begin errors++; $display("FAIL sweep_latency lat%0d got %0d want %0d", lats[g], lat[g], 16 + lats[g]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_pts = '0;
    b_pts = '0;
    test_reset();
    test_basic();
    test_extreme();
    test_hold();
    test_abort();
    test_back_to_back();
    test_lat_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
